// File: rtl/mac_block_pipe.sv
// Two-stage pipelined MAC slice: per-lane partial products in stage 1, composite
// product recombination plus accumulate/saturate in stage 2.
module mac_block_pipe #(
   parameter int MIN_WIDTH = 8,
   parameter int LANES     = 4,
   parameter int ACC_WIDTH = 48
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [1:0]                   cfg_mode,
   input  logic                         cfg_acc_en,
   input  logic                         cfg_signed,
   input  logic                         cfg_sat,
   input  logic [ACC_WIDTH-1:0]         init_val,
   input  logic                         load,
   input  logic                         in_valid,
   input  logic [LANES*MIN_WIDTH-1:0]   a,
   input  logic [MIN_WIDTH-1:0]         b,
   output logic [LANES*MIN_WIDTH-1:0]   a_out,
   output logic                         out_valid,
   output logic [ACC_WIDTH-1:0]         c,
   output logic                         ovf
);

   localparam int AW = LANES * MIN_WIDTH;
   localparam int PW = 2 * MIN_WIDTH;
   localparam logic [ACC_WIDTH-1:0] S_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] S_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   // Handshake: a beat is taken whenever in_valid=1 at a rising edge; there is
   // no backpressure, and out_valid pulses for one cycle two edges later.

   // stage 1 state
   logic [PW-1:0]          pp_q [LANES];
   logic [PW-1:0]          pp_d [LANES];
   logic                   v1_q, v1_d;
   logic [1:0]             mode_q, mode_d;
   logic                   acc_en_q, acc_en_d;
   logic                   signed_q, signed_d;
   logic                   sat_q, sat_d;
   logic [AW-1:0]          a_out_q, a_out_d;
   logic [MIN_WIDTH-1:0]   b_q, b_d;

   // stage 2 state
   logic                   ov_q, ov_d;
   logic [ACC_WIDTH-1:0]   c_q, c_d;
   logic [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic                   ovf_q, ovf_d;

   // stage 2 datapath
   int                     n_act;
   logic                   mode_ok;
   logic                   a_neg, b_neg;
   logic [ACC_WIDTH-1:0]   p_u, p_s, p, a_act;
   logic [ACC_WIDTH-1:0]   base, sum, sat_val, acc_res;
   logic [ACC_WIDTH:0]     sum_x;
   logic                   ovf_now;

   always_comb begin
      v1_d     = in_valid;
      mode_d   = in_valid ? cfg_mode   : mode_q;
      acc_en_d = in_valid ? cfg_acc_en : acc_en_q;
      signed_d = in_valid ? cfg_signed : signed_q;
      sat_d    = in_valid ? cfg_sat    : sat_q;
      a_out_d  = in_valid ? a          : a_out_q;
      b_d      = in_valid ? b          : b_q;
      for (int i = 0; i < LANES; i++) begin
         pp_d[i] = in_valid ? PW'(a[i*MIN_WIDTH +: MIN_WIDTH]) * PW'(b) : pp_q[i];
      end
   end

   always_comb begin
      case (mode_q)
         2'b00:   n_act = 1;
         2'b01:   n_act = 2;
         2'b10:   n_act = 4;
         default: n_act = 8;
      endcase
      mode_ok = (n_act <= LANES);

      p_u   = '0;
      a_act = '0;
      a_neg = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (i < n_act) begin
            p_u   = p_u + (ACC_WIDTH'(pp_q[i]) << (i*MIN_WIDTH));
            a_act = a_act | (ACC_WIDTH'(a_out_q[i*MIN_WIDTH +: MIN_WIDTH]) << (i*MIN_WIDTH));
         end
         if (i == n_act - 1) a_neg = a_out_q[i*MIN_WIDTH + MIN_WIDTH - 1];
      end
      b_neg = b_q[MIN_WIDTH-1];

      // Signed product from the unsigned one: remove the weight the sign bits
      // carried as unsigned values, working modulo 2^ACC_WIDTH.
      p_s = p_u
          - (a_neg ? (ACC_WIDTH'(b_q) << (n_act*MIN_WIDTH)) : '0)
          - (b_neg ? (a_act << MIN_WIDTH) : '0)
          + ((a_neg && b_neg) ? (ACC_WIDTH'(1) << (n_act*MIN_WIDTH + MIN_WIDTH)) : '0);

      p = !mode_ok ? '0 : (signed_q ? p_s : p_u);

      base    = load ? init_val : acc_q;
      sum_x   = {1'b0, base} + {1'b0, p};
      sum     = sum_x[ACC_WIDTH-1:0];
      ovf_now = signed_q ? ((base[ACC_WIDTH-1] == p[ACC_WIDTH-1]) &&
                            (sum[ACC_WIDTH-1] != base[ACC_WIDTH-1]))
                         : sum_x[ACC_WIDTH];
      sat_val = signed_q ? (p[ACC_WIDTH-1] ? S_MIN : S_MAX) : '1;
      acc_res = (ovf_now && sat_q) ? sat_val : sum;
   end

   always_comb begin
      ov_d  = 1'b0;
      c_d   = c_q;
      acc_d = acc_q;
      ovf_d = ovf_q;
      if (v1_q) begin
         ov_d = 1'b1;
         if (acc_en_q) begin
            acc_d = acc_res;
            c_d   = acc_res;
            ovf_d = load ? ovf_now : (ovf_q | ovf_now);
         end else begin
            c_d = p;
            if (load) begin
               acc_d = init_val;
               ovf_d = 1'b0;
            end
         end
      end else if (load) begin
         acc_d = init_val;
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < LANES; i++) pp_q[i] <= '0;
         v1_q     <= 1'b0;
         mode_q   <= '0;
         acc_en_q <= 1'b0;
         signed_q <= 1'b0;
         sat_q    <= 1'b0;
         a_out_q  <= '0;
         b_q      <= '0;
         ov_q     <= 1'b0;
         c_q      <= '0;
         acc_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         for (int i = 0; i < LANES; i++) pp_q[i] <= pp_d[i];
         v1_q     <= v1_d;
         mode_q   <= mode_d;
         acc_en_q <= acc_en_d;
         signed_q <= signed_d;
         sat_q    <= sat_d;
         a_out_q  <= a_out_d;
         b_q      <= b_d;
         ov_q     <= ov_d;
         c_q      <= c_d;
         acc_q    <= acc_d;
         ovf_q    <= ovf_d;
      end
   end

   assign a_out     = a_out_q;
   assign out_valid = ov_q;
   assign c         = c_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_block_pipe.sv
// Directed bench for mac_block_pipe with the default 8-bit x 4-lane, 48-bit
// accumulator configuration; expected values are worked out by hand.
module tb_mac_block_pipe;

   localparam int MW  = 8;
   localparam int LN  = 4;
   localparam int ACC = 48;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [1:0]        cfg_mode = '0;
   logic              cfg_acc_en = 1'b0;
   logic              cfg_signed = 1'b0;
   logic              cfg_sat = 1'b0;
   logic [ACC-1:0]    init_val = '0;
   logic              load = 1'b0;
   logic              in_valid = 1'b0;
   logic [LN*MW-1:0]  a = '0;
   logic [MW-1:0]     b = '0;
   logic [LN*MW-1:0]  a_out;
   logic              out_valid;
   logic [ACC-1:0]    c;
   logic              ovf;

   int total = 0;
   int bad   = 0;

   mac_block_pipe #(.MIN_WIDTH(MW), .LANES(LN), .ACC_WIDTH(ACC)) dut (
      .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_acc_en(cfg_acc_en),
      .cfg_signed(cfg_signed), .cfg_sat(cfg_sat), .init_val(init_val),
      .load(load), .in_valid(in_valid), .a(a), .b(b), .a_out(a_out),
      .out_valid(out_valid), .c(c), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [1:0] mode, input logic acc_en, input logic sgn,
                       input logic sat, input logic [LN*MW-1:0] av, input logic [MW-1:0] bv);
      cfg_mode   = mode;
      cfg_acc_en = acc_en;
      cfg_signed = sgn;
      cfg_sat    = sat;
      a          = av;
      b          = bv;
      in_valid   = 1'b1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      load     = 1'b0;
   endtask

   task automatic check(input string tag, input logic [ACC-1:0] obs, input logic [ACC-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      // reset
      tick(); tick();
      check("rst_out_valid", ACC'(out_valid), 0);
      check("rst_c", c, 0);
      check("rst_ovf", ACC'(ovf), 0);
      check("rst_a_out", ACC'(a_out), 0);
      rst = 1'b1;
      tick();

      // single unsigned mult-only, latency and one-cycle pulse
      beat(2'b00, 0, 0, 0, 32'h0000_00FF, 8'hFF);
      tick();
      check("a_out_capture", ACC'(a_out), 48'hFF);
      check("lat1_no_valid", ACC'(out_valid), 0);
      idle();
      tick();
      check("single_valid", ACC'(out_valid), 1);
      check("single_c", c, 48'h0000_0000_FE01);
      tick();
      check("single_pulse_end", ACC'(out_valid), 0);
      check("single_c_hold", c, 48'h0000_0000_FE01);
      check("a_out_hold", ACC'(a_out), 48'hFF);

      // dual vs single on the same A lanes, back to back
      beat(2'b01, 0, 0, 0, 32'h0000_1234, 8'h10);
      tick();
      beat(2'b00, 0, 0, 0, 32'h0000_1234, 8'h10);
      tick();
      check("dual_c", c, 48'h0000_0001_2340);
      idle();
      tick();
      check("dual_single_valid", ACC'(out_valid), 1);
      check("dual_single_c", c, 48'h0000_0000_0340);

      // quad signed vs unsigned
      beat(2'b10, 0, 1, 0, 32'hFFFF_FFFF, 8'h02);
      tick();
      beat(2'b10, 0, 0, 0, 32'hFFFF_FFFF, 8'h02);
      tick();
      check("quad_signed_c", c, 48'hFFFF_FFFF_FFFE);
      idle();
      tick();
      check("quad_unsigned_c", c, 48'h0001_FFFF_FFFE);

      // upper lanes ignored, reserved mode, signed corner cases
      beat(2'b00, 0, 0, 0, 32'hAABB_CC05, 8'h03);
      tick();
      beat(2'b11, 0, 0, 0, 32'h1111_1111, 8'h11);
      tick();
      check("lanes_ignored_c", c, 48'h0F);
      beat(2'b00, 0, 1, 0, 32'h0000_0080, 8'h80);
      tick();
      check("reserved_valid", ACC'(out_valid), 1);
      check("reserved_c", c, 48'h0);
      beat(2'b01, 0, 1, 0, 32'h0000_0003, 8'hFF);
      tick();
      check("signed_neg_neg", c, 48'h4000);
      idle();
      tick();
      check("signed_dual_negb", c, 48'hFFFF_FFFF_FFFD);
      tick();

      // accumulate: load then three beats of 3*4, then load coincident with a beat
      init_val = 48'd100;
      load = 1'b1;
      tick();
      check("load_no_valid", ACC'(out_valid), 0);
      load = 1'b0;
      beat(2'b00, 1, 0, 0, 32'd3, 8'd4);
      tick();
      tick();
      check("acc_112", c, 48'd112);
      tick();
      check("acc_124", c, 48'd124);
      idle();
      tick();
      check("acc_136", c, 48'd136);
      beat(2'b00, 1, 0, 0, 32'd3, 8'd4);
      tick();
      in_valid = 1'b0;
      load = 1'b1;
      tick();
      check("acc_load_coincident", c, 48'd112);
      check("acc_load_coincident_valid", ACC'(out_valid), 1);
      load = 1'b0;

      // multiply-only leaves the accumulator alone
      beat(2'b00, 0, 0, 0, 32'd1, 8'd1);
      tick();
      beat(2'b00, 1, 0, 0, 32'd3, 8'd4);
      tick();
      check("mult_only_c", c, 48'd1);
      idle();
      tick();
      check("acc_after_mult", c, 48'd124);

      // signed overflow with saturation; load in an empty stage 2 keeps c
      init_val = 48'h7FFF_FFFF_FFF0;
      load = 1'b1;
      tick();
      check("load_c_unchanged", c, 48'd124);
      load = 1'b0;
      beat(2'b00, 1, 1, 1, 32'h7F, 8'h01);
      tick();
      idle();
      tick();
      check("sat_signed_c", c, 48'h7FFF_FFFF_FFFF);
      check("sat_signed_ovf", ACC'(ovf), 1);
      load = 1'b1;
      tick();
      check("load_clears_ovf", ACC'(ovf), 0);

      // unsigned overflow with saturation, stickiness, coincident load clearing
      init_val = 48'hFFFF_FFFF_FFFF;
      tick();
      load = 1'b0;
      beat(2'b00, 1, 0, 1, 32'h01, 8'h01);
      tick();
      beat(2'b00, 0, 0, 0, 32'h02, 8'h02);
      tick();
      check("sat_unsigned_c", c, 48'hFFFF_FFFF_FFFF);
      check("sat_unsigned_ovf", ACC'(ovf), 1);
      beat(2'b00, 1, 0, 0, 32'h01, 8'h01);
      tick();
      check("mult_keeps_ovf", ACC'(ovf), 1);
      check("mult_c", c, 48'd4);
      in_valid = 1'b0;
      init_val = 48'd5;
      load = 1'b1;
      tick();
      check("coinc_load_c", c, 48'd6);
      check("coinc_load_ovf", ACC'(ovf), 0);

      // signed overflow, wrap mode
      init_val = 48'h7FFF_FFFF_FFF0;
      tick();
      load = 1'b0;
      beat(2'b00, 1, 1, 0, 32'h7F, 8'h01);
      tick();
      idle();
      tick();
      check("wrap_signed_c", c, 48'h8000_0000_006F);
      check("wrap_signed_ovf", ACC'(ovf), 1);

      // reset while a beat sits in stage 1
      beat(2'b00, 0, 0, 0, 32'h11, 8'h02);
      tick();
      idle();
      rst = 1'b0;
      #1;
      check("mid_rst_out_valid", ACC'(out_valid), 0);
      check("mid_rst_c", c, 0);
      check("mid_rst_ovf", ACC'(ovf), 0);
      check("mid_rst_a_out", ACC'(a_out), 0);
      tick();
      rst = 1'b1;
      tick();
      check("dropped_beat", ACC'(out_valid), 0);
      beat(2'b00, 0, 0, 0, 32'h05, 8'h03);
      tick();
      check("post_rst_lat1", ACC'(out_valid), 0);
      idle();
      tick();
      check("post_rst_valid", ACC'(out_valid), 1);
      check("post_rst_c", c, 48'd15);
      tick();
      check("post_rst_pulse_end", ACC'(out_valid), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mac_block_pipe.md
Name: mac_block_pipe

Overview:
Parametrised, fully pipelined successor to the single/dual/quad MAC slice. One MIN_WIDTH operand B multiplies a composite A built from 1, 2 or 4 (up to LANES) MIN_WIDTH lanes. The result goes out either as a plain product or into a wide accumulator. Adds a valid handshake, a signed mode, optional saturation, a sticky overflow flag and a registered A forward for cascading slices in the MAC cluster.

Parameters:
MIN_WIDTH, 8, width of one A lane and of B.
LANES, 4, number of A lanes; power of two, 1..8.
ACC_WIDTH, 48, accumulator/output width; must be >= (LANES+1)*MIN_WIDTH.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-low reset.
cfg_mode  in  2  00 single (1 lane), 01 dual (2), 10 quad (4), 11 reserved; 8-lane is reachable only when LANES=8, via 11.
cfg_acc_en  in  1  1 = accumulate, 0 = multiply-only.
cfg_signed  in  1  1 = composite A and B are two's complement.
cfg_sat  in  1  1 = saturate accumulator on overflow, 0 = wrap.
init_val  in  ACC_WIDTH  accumulator load value.
load  in  1  load init_val into the accumulator (stage-2 timing).
in_valid  in  1  beat present on a/b/cfg_*.
a  in  LANES*MIN_WIDTH  A lanes; lane 0 is least significant.
b  in  MIN_WIDTH  B operand.
a_out  out  LANES*MIN_WIDTH  registered copy of a, for cascading.
out_valid  out  1  c holds a new result.
c  out  ACC_WIDTH  product or accumulator value.
ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (rst=0, asynchronous): all state cleared. out_valid=0, c=0, ovf=0, a_out=0, accumulator=0. Any in-flight beats are dropped and never produce out_valid.
- Stage 1 (cycle t, in_valid=1):
  - registers the per-lane partial products a[i]*b, each 2*MIN_WIDTH wide;
  - captures cfg_mode, cfg_acc_en, cfg_signed and cfg_sat with the beat, so config changes affect only later beats;
  - a_out <= a. a_out holds its value when in_valid=0.
- Stage 2 (cycle t+1):
  - Product P = sum over active lanes of (pp[i] << i*MIN_WIDTH).
  - Lanes above the active count are ignored.
  - Reserved or unsupported mode gives P=0.
  - Signed mode: P equals the two's-complement product of the active-width A and B, sign-extended to ACC_WIDTH. Unsigned mode zero-extends.
- Output timing: out_valid asserts exactly 2 cycles after in_valid, for 1 cycle per beat. Back-to-back beats give back-to-back results. No backpressure.
- Multiply-only: c <= P. The accumulator is untouched.
- Accumulate: acc <= acc + P and c <= new acc.
  - Overflow is signed or unsigned per the captured cfg_signed.
  - On overflow: cfg_sat=1 clamps to the max/min representable value; cfg_sat=0 wraps modulo 2^ACC_WIDTH.
  - ovf is set on any overflow in either case.
- load=1 with no stage-2 beat: acc <= init_val, ovf <= 0, out_valid=0, c unchanged.
- load=1 in the same cycle as a stage-2 accumulate beat: acc <= init_val + P, with the overflow rules applied to that sum. c shows that result and ovf reflects only that sum.
- When out_valid=0, c holds its last value.

Test Plan:
- Single, unsigned, mult-only: a lane0=0xFF, b=0xFF, in_valid 1 cycle at t → at t+2 out_valid=1 and c=0x00000000FE01; out_valid=0 at t+3.
- Dual, unsigned: a[15:0]=0x1234, b=0x10 → c=0x000000012340. Same beat in single mode → c=0x340 (0x34*0x10).
- Quad, signed: a=0xFFFFFFFF (-1), b=0x02 → c=0xFFFFFFFFFFFE. Unsigned repeat → c=0x1FFFFFFFE.
- Accumulate: load with init_val=100, then 3 consecutive single beats 3*4 → c=112, 124, 136 on consecutive cycles. load coincident with the 4th beat → c=112.
- Overflow: signed, init 0x7FFFFFFFFFF0, single beat 0x7F*0x01. cfg_sat=1 → c=0x7FFFFFFFFFFF, ovf=1. cfg_sat=0 → c=0x80000000006F, ovf=1. A following load clears ovf.
- Reset mid-operation: beat in stage 1, then rst=0 for 1 cycle → out_valid never asserts and c=0, ovf=0, a_out=0. The next beat after release returns to normal 2-cycle latency.
